// File: rtl/iic_pkg.sv
// iic_pkg: state codes, bit-count constants and defaults shared by the
// I2C responder and its bus synchroniser.
package iic_pkg;

    // 8-bit state codes; same numbering as the master's nstate debug codes.
    typedef enum logic [7:0] {
        ST_IDLE    = 8'h00,
        ST_DEVADDR = 8'h01,
        ST_ACK_DEV = 8'h02,
        ST_REG_HI  = 8'h03,
        ST_ACK_HI  = 8'h04,
        ST_REG_LO  = 8'h05,
        ST_ACK_LO  = 8'h06,
        ST_WR_DATA = 8'h07,
        ST_ACK_WR  = 8'h08,
        ST_RD_LOAD = 8'h09,
        ST_RD_DATA = 8'h0A,
        ST_RD_ACK  = 8'h0B
    } iic_state_e;

    localparam logic [3:0] IIC_BYTE_BITS    = 4'd8;
    localparam logic [6:0] IIC_DEV_ADDR_DEF = 7'h3C;
    // clk_8m cycles from a detected SCL fall to an SDA update; three cycles
    // leaves room for the read-data fetch before the first bit goes out.
    localparam int         IIC_DRV_DLY      = 3;

    // States in which SCL pulses shift a data bit (in or out).
    function automatic logic is_rx_state(input iic_state_e s);
        return (s == ST_DEVADDR) || (s == ST_REG_HI) || (s == ST_REG_LO) ||
               (s == ST_WR_DATA) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/iic_bus_sync.sv
// iic_bus_sync: SYNC_STAGES-deep synchroniser on SCL/SDA plus SCL edge and
// START/STOP condition detection on the synchronised pair.
module iic_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_8m,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s;

    // Synchroniser chains plus one history stage; the bus idles high.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s_o;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s_o    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s_o;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s_o;

endmodule

// File: rtl/iic_slave_resp.sv
// iic_slave_resp: I2C target with 7-bit device address, 16-bit register
// pointer and 8-bit data, driving a synchronous register port.
// Optional: IIC_SLV_AUTOINC_EN makes reg_addr advance after every data byte.
module iic_slave_resp
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = IIC_DEV_ADDR_DEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_8m,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        err,
    output logic [7:0]  nstate,
    output logic [15:0] Rec_count
);
    iic_state_e             state_q, state_d;
    logic [3:0]             cnt_q;
    logic                   bit_q, bit_vld_q, rw_q, we_q, ld_q;
    logic                   busy_q, err_q, sda_t_q, drive_rel;
    logic [7:0]             shift_q, reg_hi_q, wdata_q;
    logic [15:0]            addr_q, rec_q;
    logic [IIC_DRV_DLY-1:0] upd_q;
    logic                   sda_s, scl_rise, scl_fall, start, stop;
    logic                   bit_done, byte_done, rb_err;
    logic [7:0]             rx_byte;

    iic_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_8m     (clk_8m),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    // A bit is committed on the SCL fall that follows its sampling rise, so
    // the rise that opens a STOP/Sr is never mistaken for a data bit.
    assign bit_done  = scl_fall & bit_vld_q;
    assign byte_done = bit_done & (cnt_q == IIC_BYTE_BITS - 4'd1);
    assign rx_byte   = {shift_q[6:0], bit_q};
    assign rb_err    = scl_rise & ~sda_t_q & sda_s;

    // State register.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; START/STOP override every state.
    always_comb begin
        state_d = state_q;
        if (start)     state_d = ST_DEVADDR;
        else if (stop) state_d = ST_IDLE;
        else begin
            case (state_q)
                ST_DEVADDR: if (byte_done)
                    state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ACK_DEV : ST_IDLE;
                ST_ACK_DEV: if (bit_done) state_d = rw_q ? ST_RD_LOAD : ST_REG_HI;
                ST_REG_HI:  if (byte_done) state_d = ST_ACK_HI;
                ST_ACK_HI:  if (bit_done)  state_d = ST_REG_LO;
                ST_REG_LO:  if (byte_done) state_d = ST_ACK_LO;
                ST_ACK_LO:  if (bit_done)  state_d = ST_WR_DATA;
                ST_WR_DATA: if (byte_done) state_d = ST_ACK_WR;
                ST_ACK_WR:  if (bit_done)  state_d = ST_WR_DATA;
                ST_RD_LOAD: state_d = ST_RD_DATA;
                ST_RD_DATA: if (byte_done) state_d = ST_RD_ACK;
                ST_RD_ACK:  if (bit_done)  state_d = bit_q ? ST_IDLE : ST_RD_LOAD;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state: read strobe and the SDA value to apply.
    always_comb begin
        reg_re    = (state_q == ST_RD_LOAD);
        drive_rel = 1'b1;
        case (state_q)
            ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: drive_rel = 1'b0;
            ST_RD_DATA: drive_rel = shift_q[7];
            default:    drive_rel = 1'b1;
        endcase
    end

    // Datapath: bit capture, shift register, pointer, strobes, flags, SDA.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            bit_q     <= 1'b1;
            bit_vld_q <= 1'b0;
            rw_q      <= 1'b0;
            we_q      <= 1'b0;
            ld_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            sda_t_q   <= 1'b1;
            shift_q   <= '0;
            reg_hi_q  <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            rec_q     <= '0;
            upd_q     <= '0;
        end else begin
            upd_q <= {upd_q[IIC_DRV_DLY-2:0], scl_fall};
            ld_q  <= (state_q == ST_RD_LOAD);
            we_q  <= 1'b0;

            if (scl_rise) begin
                bit_q     <= sda_s;
                bit_vld_q <= 1'b1;
            end else if (scl_fall || start) begin
                bit_vld_q <= 1'b0;
            end

            // reg_rdata is valid the cycle after reg_re.
            if (start || stop) cnt_q <= '0;
            else if (ld_q) shift_q <= reg_rdata;
            else if (bit_done && is_rx_state(state_q)) begin
                shift_q <= rx_byte;
                cnt_q   <= byte_done ? 4'd0 : cnt_q + 4'd1;
            end

            if (state_q == ST_DEVADDR && byte_done) rw_q <= rx_byte[0];
            if (state_q == ST_REG_HI && byte_done) reg_hi_q <= rx_byte;
            if (state_q == ST_WR_DATA && byte_done) begin
                wdata_q <= rx_byte;
                we_q    <= 1'b1;
            end

            if (state_q == ST_REG_LO && byte_done) addr_q <= {reg_hi_q, rx_byte};
`ifdef IIC_SLV_AUTOINC_EN
            else if (we_q || ld_q) addr_q <= addr_q + 16'd1;
`endif

            if (stop) busy_q <= 1'b0;
            else if (state_q == ST_DEVADDR && byte_done)
                busy_q <= (rx_byte[7:1] == DEV_ADDR);

            if (((start || stop) && cnt_q != 4'd0) || rb_err) err_q <= 1'b1;
            else if (start) err_q <= 1'b0;

            if (start) rec_q <= '0;
            else if (byte_done && (state_q == ST_WR_DATA || state_q == ST_RD_DATA) &&
                     rec_q != 16'hFFFF)
                rec_q <= rec_q + 16'd1;

            if (start || stop) sda_t_q <= 1'b1;
            else if (upd_q[IIC_DRV_DLY-1]) sda_t_q <= drive_rel;
        end
    end

    assign sda_o     = 1'b0;
    assign sda_t     = sda_t_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign nstate    = state_q;
    assign Rec_count = rec_q;

endmodule

// File: tb/tb_iic_slave_resp.sv
// tb_iic_slave_resp: bit-banged I2C master against iic_slave_resp, with a
// scoreboard of expected register-port writes and read requests.
module tb_iic_slave_resp;
    localparam int Q = 10;   // clk_8m cycles per quarter SCL period

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1, m_sda = 1'b1;
    logic [7:0]  rdata_val = 8'h00;
    logic        sda_o, sda_t, reg_we, reg_re, busy, err;
    logic [15:0] reg_addr, Rec_count;
    logic [7:0]  reg_wdata, nstate;
    logic        sda_bus;

    wr_exp_t     exp_wr[$];
    logic [15:0] exp_rd[$];
    wr_exp_t     mon_w;
    logic [15:0] mon_a;
    int          n_chk = 0, n_err = 0, re_cnt = 0;

    assign sda_bus = m_sda & (sda_t | sda_o);

    always #5 clk = ~clk;

    iic_slave_resp #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
        .clk_8m    (clk),
        .rst_n     (rst_n),
        .scl_i     (m_scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (rdata_val),
        .busy      (busy),
        .err       (err),
        .nstate    (nstate),
        .Rec_count (Rec_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register-port monitor: pops the scoreboard on each strobe.
    always @(negedge clk) begin
        if (rst_n && reg_we) begin
            chk("we_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                mon_w = exp_wr.pop_front();
                chk("we_addr", reg_addr, mon_w.addr);
                chk("we_data", reg_wdata, mon_w.data);
            end
        end
        if (rst_n && reg_re) begin
            re_cnt++;
            chk("re_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) begin
                mon_a = exp_rd.pop_front();
                chk("re_addr", reg_addr, mon_a);
            end
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    // One SCL pulse with the master driving b; returns the bus level at SCL high.
    task automatic clk_bit(input logic b, output logic seen);
        m_sda = b;    wq();
        m_scl = 1'b1; wq();
        seen  = sda_bus; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic ninth);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, ninth);
    endtask

    initial begin
        logic        ack, ninth;
        logic [7:0]  d;
        logic [15:0] ptr;
        int          re0;

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_sda_t", sda_t, 1);
        chk("rst_sda_o", sda_o, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_state", nstate, 8'h00);
        chk("rst_rec", Rec_count, 0);

        // Single write 0x3008 <= 0x82.
        exp_wr.push_back('{addr: 16'h3008, data: 8'h82});
        i2c_start();
        write_byte(8'h78, ack); chk("w_ack_dev", ack, 0);
        write_byte(8'h30, ack); chk("w_ack_hi", ack, 0);
        write_byte(8'h08, ack); chk("w_ack_lo", ack, 0);
        write_byte(8'h82, ack); chk("w_ack_data", ack, 0);
        chk("w_busy", busy, 1);
        i2c_stop();
        chk("w_busy_stop", busy, 0);
        chk("w_rec", Rec_count, 1);
        chk("w_left", exp_wr.size(), 0);

        // Random read with repeated START, master NACKs the only byte.
        rdata_val = 8'h56;
        re0 = re_cnt;
        exp_rd.push_back(16'h300A);
        i2c_start();
        write_byte(8'h78, ack); chk("r_ack_dev", ack, 0);
        write_byte(8'h30, ack); chk("r_ack_hi", ack, 0);
        write_byte(8'h0A, ack); chk("r_ack_lo", ack, 0);
        i2c_start();
        write_byte(8'h79, ack); chk("r_ack_devr", ack, 0);
        read_byte(1'b1, d, ninth);
        chk("r_data", d, 8'h56);
        chk("r_rel9", ninth, 1);
        i2c_stop();
        chk("r_re_cnt", re_cnt - re0, 1);
        chk("r_rec", Rec_count, 1);
`ifdef IIC_SLV_AUTOINC_EN
        chk("r_addr", reg_addr, 16'h300B);
`else
        chk("r_addr", reg_addr, 16'h300A);
`endif

        // Foreign address 0x3D: ignored entirely.
        i2c_start();
        write_byte(8'h7A, ack); chk("x_noack", ack, 1);
        chk("x_busy", busy, 0);
        write_byte(8'h11, ack); chk("x_noack_data", ack, 1);
        i2c_stop();
        chk("x_state", nstate, 8'h00);
        chk("x_err", err, 0);

        // Burst of three writes starting at 0xFFFF.
`ifdef IIC_SLV_AUTOINC_EN
        exp_wr.push_back('{addr: 16'hFFFF, data: 8'hA1});
        exp_wr.push_back('{addr: 16'h0000, data: 8'hA2});
        exp_wr.push_back('{addr: 16'h0001, data: 8'hA3});
        ptr = 16'h0002;
`else
        exp_wr.push_back('{addr: 16'hFFFF, data: 8'hA1});
        exp_wr.push_back('{addr: 16'hFFFF, data: 8'hA2});
        exp_wr.push_back('{addr: 16'hFFFF, data: 8'hA3});
        ptr = 16'hFFFF;
`endif
        i2c_start();
        write_byte(8'h78, ack); chk("b_ack_dev", ack, 0);
        write_byte(8'hFF, ack); chk("b_ack_hi", ack, 0);
        write_byte(8'hFF, ack); chk("b_ack_lo", ack, 0);
        for (int i = 1; i <= 3; i++) begin
            write_byte(8'hA0 + 8'(i), ack);
            chk("b_ack_data", ack, 0);
        end
        i2c_stop();
        chk("b_rec", Rec_count, 3);
        chk("b_left", exp_wr.size(), 0);

        // STOP after four bits of the register byte.
        i2c_start();
        write_byte(8'h78, ack); chk("e_ack_dev", ack, 0);
        for (int i = 0; i < 4; i++) clk_bit(i[0], ninth);
        i2c_stop();
        chk("e_err", err, 1);
        chk("e_state", nstate, 8'h00);
        i2c_start();
        chk("e_err_clr", err, 0);
        chk("e_state_dev", nstate, 8'h01);

        // Reset while the responder is pulling SDA low for a 0 data bit.
        rdata_val = 8'h00;
        exp_rd.push_back(ptr);
        write_byte(8'h79, ack); chk("z_ack_dev", ack, 0);
        chk("z_state", nstate, 8'h0A);
        chk("z_driving", sda_t, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("z_rel_async", sda_t, 1);
        chk("z_addr", reg_addr, 0);
        chk("z_busy", busy, 0);
        chk("z_err", err, 0);
        chk("z_state_rst", nstate, 8'h00);
        chk("z_rec", Rec_count, 0);
        chk("z_we", reg_we, 0);
        chk("z_re", reg_re, 0);
        chk("z_wdata", reg_wdata, 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("z_rd_left", exp_rd.size(), 0);
        chk("z_wr_left", exp_wr.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
